smart_systolic_tile: RTL and testbench

SMART_SYSTOLIC_TILE -- requirements
Module: smart_systolic_tile

---
 rtl/smart_systolic_tile.sv | 265 ++++++++++++++++++++++++++
 tb/tb_smart_systolic_tile.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smart_systolic_tile.sv
// Output-stationary ROWS x COLS systolic MAC tile with input skewing, row-serial result drain
// and a registered smart-bus bypass path for chaining tiles.
module smart_systolic_tile #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACC_SIZE  = 40,
    parameter int K_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [K_WIDTH-1:0]       k_len,
    input  logic                     bypass_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*WORD_SIZE-1:0] left_in_bus,
    input  logic [COLS*WORD_SIZE-1:0] top_in_bus,
    output logic [ROWS*WORD_SIZE-1:0] right_out_bus,
    output logic [COLS*WORD_SIZE-1:0] bottom_out_bus,
    input  logic [ROWS*WORD_SIZE-1:0] hor_smart_bus_in,
    input  logic [COLS*WORD_SIZE-1:0] ver_smart_bus_in,
    output logic [ROWS*WORD_SIZE-1:0] hor_smart_bus_out,
    output logic [COLS*WORD_SIZE-1:0] ver_smart_bus_out,
    output logic [COLS*ACC_SIZE-1:0]  result_bus,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int RowW   = $clog2(ROWS);
    localparam int FlushW = $clog2(ROWS + COLS);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(ROWS + COLS - 2);
    localparam logic [RowW-1:0]   RowLast   = RowW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StCompute, StFlush, StDrain} state_e;

    state_e              state_q, state_d;
    logic [K_WIDTH-1:0]  beat_q, beat_d;
    logic [FlushW-1:0]   flush_q, flush_d;
    logic [RowW-1:0]     row_q, row_d;
    logic                done_q, done_d;
    logic                accept, clear;

    assign accept = (state_q == StCompute) && in_valid;
    assign clear  = (state_q == StIdle) && start && (k_len != '0);

    // Skewed operand streams feeding the west edge and north edge of the array.
    logic [WORD_SIZE-1:0] row_a  [ROWS];
    logic                 row_av [ROWS];
    logic [WORD_SIZE-1:0] col_b  [COLS];
    logic                 col_bv [COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        if (r == 0) begin : g_direct
            assign row_a[r]  = accept ? left_in_bus[WORD_SIZE-1:0] : '0;
            assign row_av[r] = accept;
        end else begin : g_delay
            logic [WORD_SIZE-1:0] d_q [r];
            logic                 v_q [r];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < r; j++) begin
                        d_q[j] <= '0;
                        v_q[j] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= accept ? left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
                    v_q[0] <= accept;
                    for (int j = 1; j < r; j++) begin
                        d_q[j] <= d_q[j-1];
                        v_q[j] <= v_q[j-1];
                    end
                end
            end
            assign row_a[r]  = d_q[r-1];
            assign row_av[r] = v_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        if (c == 0) begin : g_direct
            assign col_b[c]  = accept ? top_in_bus[WORD_SIZE-1:0] : '0;
            assign col_bv[c] = accept;
        end else begin : g_delay
            logic [WORD_SIZE-1:0] d_q [c];
            logic                 v_q [c];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < c; j++) begin
                        d_q[j] <= '0;
                        v_q[j] <= 1'b0;
                    end
                end else begin
                    d_q[0] <= accept ? top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
                    v_q[0] <= accept;
                    for (int j = 1; j < c; j++) begin
                        d_q[j] <= d_q[j-1];
                        v_q[j] <= v_q[j-1];
                    end
                end
            end
            assign col_b[c]  = d_q[c-1];
            assign col_bv[c] = v_q[c-1];
        end
    end

    logic [WORD_SIZE-1:0] pe_a   [ROWS][COLS];
    logic                 pe_av  [ROWS][COLS];
    logic [WORD_SIZE-1:0] pe_b   [ROWS][COLS];
    logic                 pe_bv  [ROWS][COLS];
    logic [ACC_SIZE-1:0]  pe_acc [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic [WORD_SIZE-1:0]         a_in, b_in, a_q, b_q;
            logic                         av_in, bv_in, av_q, bv_q;
            logic [ACC_SIZE-1:0]          acc_q, acc_d;
            logic signed [2*WORD_SIZE-1:0] prod;

            if (c == 0) begin : g_west
                assign a_in  = row_a[r];
                assign av_in = row_av[r];
            end else begin : g_west
                assign a_in  = pe_a[r][c-1];
                assign av_in = pe_av[r][c-1];
            end
            if (r == 0) begin : g_north
                assign b_in  = col_b[c];
                assign bv_in = col_bv[c];
            end else begin : g_north
                assign b_in  = pe_b[r-1][c];
                assign bv_in = pe_bv[r-1][c];
            end

            assign prod = $signed(a_in) * $signed(b_in);

            // Signed cast sign-extends the product; the add wraps modulo 2^ACC_SIZE.
            always_comb begin
                acc_d = acc_q;
                if (clear) begin
                    acc_d = '0;
                end else if (av_in && bv_in) begin
                    acc_d = acc_q + ACC_SIZE'(prod);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    av_q  <= 1'b0;
                    bv_q  <= 1'b0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    av_q  <= av_in;
                    bv_q  <= bv_in;
                    acc_q <= acc_d;
                end
            end

            assign pe_a[r][c]   = a_q;
            assign pe_av[r][c]  = av_q;
            assign pe_b[r][c]   = b_q;
            assign pe_bv[r][c]  = bv_q;
            assign pe_acc[r][c] = acc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    beat_d  = k_len;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if (in_valid) begin
                    beat_d = beat_q - K_WIDTH'(1);
                    if (beat_q == K_WIDTH'(1)) begin
                        flush_d = FlushLast;
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                if (flush_q == '0) begin
                    row_d   = '0;
                    state_d = StDrain;
                end else begin
                    flush_d = flush_q - FlushW'(1);
                end
            end
            StDrain: begin
                if (result_ready) begin
                    if (row_q == RowLast) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            beat_q            <= '0;
            flush_q           <= '0;
            row_q             <= '0;
            done_q            <= 1'b0;
            hor_smart_bus_out <= '0;
            ver_smart_bus_out <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
            // Bypass only when idle and no job is being requested this cycle.
            if ((state_q == StIdle) && bypass_en && !start) begin
                hor_smart_bus_out <= hor_smart_bus_in;
                ver_smart_bus_out <= ver_smart_bus_in;
            end else begin
                hor_smart_bus_out <= '0;
                ver_smart_bus_out <= '0;
            end
        end
    end

    always_comb begin
        right_out_bus  = '0;
        bottom_out_bus = '0;
        result_bus     = '0;
        for (int r = 0; r < ROWS; r++) begin
            right_out_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE] =
                pe_av[r][COLS-1] ? pe_a[r][COLS-1] : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            bottom_out_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE] =
                pe_bv[ROWS-1][c] ? pe_b[ROWS-1][c] : '0;
            if (state_q == StDrain) begin
                result_bus[(c+1)*ACC_SIZE-1 -: ACC_SIZE] = pe_acc[row_q][c];
            end
        end
    end

    assign in_ready     = (state_q == StCompute);
    assign result_valid = (state_q == StDrain);
    assign busy         = (state_q != StIdle);
    assign done         = done_q;

endmodule

// File: tb/tb_smart_systolic_tile.sv
// Directed bench for smart_systolic_tile (2x2): vector table of small matrix jobs plus
// hand-written sequences for back-pressure, bypass, mid-job reset and zero-length starts.
module tb_smart_systolic_tile;

    localparam int W = 16;
    localparam int R = 2;
    localparam int C = 2;
    localparam int A = 40;
    localparam int K = 8;

    logic           clk = 1'b0;
    logic           rst, start, bypass_en, in_valid, in_ready;
    logic [K-1:0]   k_len;
    logic [R*W-1:0] left_in_bus, right_out_bus, hor_smart_bus_in, hor_smart_bus_out;
    logic [C*W-1:0] top_in_bus, bottom_out_bus, ver_smart_bus_in, ver_smart_bus_out;
    logic [C*A-1:0] result_bus;
    logic           result_valid, result_ready, busy, done;

    smart_systolic_tile #(
        .WORD_SIZE(W), .ROWS(R), .COLS(C), .ACC_SIZE(A), .K_WIDTH(K)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .k_len            (k_len),
        .bypass_en        (bypass_en),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .left_in_bus      (left_in_bus),
        .top_in_bus       (top_in_bus),
        .right_out_bus    (right_out_bus),
        .bottom_out_bus   (bottom_out_bus),
        .hor_smart_bus_in (hor_smart_bus_in),
        .ver_smart_bus_in (ver_smart_bus_in),
        .hor_smart_bus_out(hor_smart_bus_out),
        .ver_smart_bus_out(ver_smart_bus_out),
        .result_bus       (result_bus),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]        k;
        logic              gap;
        logic [3:0]        hold;
        logic [3:0][31:0]  left;
        logic [3:0][31:0]  top;
        logic [3:0][39:0]  exp;
    } vec_t;

    vec_t tbl [6];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] pk(input int w0, input int w1);
        logic [15:0] lo, hi;
        lo = w0[15:0];
        hi = w1[15:0];
        return {hi, lo};
    endfunction

    function automatic logic [39:0] ex(input longint v);
        return v[39:0];
    endfunction

    function automatic vec_t mk(input int k, input logic gap, input int hold,
                                input logic [127:0] l, input logic [127:0] t,
                                input logic [159:0] e);
        vec_t v;
        v.k    = k[7:0];
        v.gap  = gap;
        v.hold = hold[3:0];
        v.left = l;
        v.top  = t;
        v.exp  = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_start(input int k);
        start = 1'b1;
        k_len = k[K-1:0];
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed_drain(input vec_t v);
        int   b;
        int   cyc;
        logic vld;
        b   = 0;
        cyc = 0;
        while (b < int'(v.k) && cyc < 64) begin
            vld         = v.gap ? (cyc % 2 == 0) : 1'b1;
            in_valid    = vld;
            // Bubble cycles carry junk data that must never reach an accumulator.
            left_in_bus = vld ? v.left[b] : 32'hDEAD_BEEF;
            top_in_bus  = vld ? v.top[b]  : 32'h1234_5678;
            chk("in_ready_compute", in_ready, 1);
            tick();
            if (vld) b++;
            cyc++;
        end
        chk("beats_taken", b, v.k);
        in_valid = 1'b0;
        if (v.k == 8'd1) begin
            tick();
            chk("right_fwd_r0", right_out_bus, v.left[0] & 32'h0000_FFFF);
            chk("bottom_fwd_c0", bottom_out_bus, v.top[0] & 32'h0000_FFFF);
            tick();
            chk("right_fwd_r1", right_out_bus, v.left[0] & 32'hFFFF_0000);
            chk("bottom_fwd_c1", bottom_out_bus, v.top[0] & 32'hFFFF_0000);
        end
        result_ready = (v.hold == 4'd0);
        cyc = 0;
        while (!result_valid && cyc < 32) begin
            tick();
            cyc++;
        end
        chk("result_valid_seen", result_valid, 1);
        for (int h = 0; h < int'(v.hold); h++) begin
            chk("hold_row0_c0", result_bus[0 +: A], v.exp[0]);
            chk("hold_row0_c1", result_bus[A +: A], v.exp[1]);
            chk("hold_valid", result_valid, 1);
            chk("hold_no_done", done, 0);
            tick();
        end
        result_ready = 1'b1;
        for (int r = 0; r < R; r++) begin
            chk("drain_valid", result_valid, 1);
            chk("drain_no_done", done, 0);
            for (int c = 0; c < C; c++) begin
                chk($sformatf("result_r%0d_c%0d", r, c), result_bus[c*A +: A], v.exp[r*C+c]);
            end
            tick();
        end
        chk("done_pulse", done, 1);
        chk("idle_after_done", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_result_bus"}, result_bus, 0);
        chk({tag, "_right"}, right_out_bus, 0);
        chk({tag, "_bottom"}, bottom_out_bus, 0);
        chk({tag, "_hor"}, hor_smart_bus_out, 0);
        chk({tag, "_ver"}, ver_smart_bus_out, 0);
    endtask

    initial begin
        tbl[0] = mk(2, 1'b0, 0,
                    {32'd0, 32'd0, pk(2, 4), pk(1, 3)},
                    {32'd0, 32'd0, pk(0, 1), pk(1, 0)},
                    {ex(4), ex(3), ex(2), ex(1)});
        tbl[1] = mk(4, 1'b1, 0, {4{pk(-3, -3)}}, {4{pk(5, 5)}}, {4{ex(-60)}});
        tbl[2] = mk(1, 1'b0, 0,
                    {32'd0, 32'd0, 32'd0, pk(2, 2)},
                    {32'd0, 32'd0, 32'd0, pk(7, 7)},
                    {4{ex(14)}});
        tbl[3] = mk(3, 1'b0, 0,
                    {32'd0, pk(3, -6), pk(-2, 5), pk(1, 4)},
                    {32'd0, pk(11, 12), pk(9, 10), pk(7, 8)},
                    {ex(10), ex(7), ex(24), ex(22)});
        tbl[4] = mk(2, 1'b0, 0,
                    {32'd0, 32'd0, pk(-32768, -32768), pk(-32768, -32768)},
                    {32'd0, 32'd0, pk(-32768, -32768), pk(-32768, -32768)},
                    {4{ex(64'sd2147483648)}});
        tbl[5] = tbl[0];
        tbl[5].hold = 4'd5;

        rst              = 1'b1;
        start            = 1'b0;
        k_len            = '0;
        bypass_en        = 1'b0;
        in_valid         = 1'b0;
        left_in_bus      = '0;
        top_in_bus       = '0;
        hor_smart_bus_in = '0;
        ver_smart_bus_in = '0;
        result_ready     = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_start(int'(tbl[i].k));
            feed_drain(tbl[i]);
        end

        // Zero-length start is ignored.
        start = 1'b1;
        k_len = '0;
        tick();
        start = 1'b0;
        chk("klen0_busy", busy, 0);
        chk("klen0_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("klen0_no_done", done, 0);
            chk("klen0_still_idle", busy, 0);
        end

        // Bypass path, then start overriding it.
        bypass_en        = 1'b1;
        hor_smart_bus_in = 32'h0000_ABCD;
        ver_smart_bus_in = 32'h5A5A_0F0F;
        tick();
        chk("bypass_hor", hor_smart_bus_out, 32'h0000_ABCD);
        chk("bypass_ver", ver_smart_bus_out, 32'h5A5A_0F0F);
        start = 1'b1;
        k_len = 8'd1;
        tick();
        start = 1'b0;
        chk("start_wins_hor", hor_smart_bus_out, 0);
        chk("start_wins_ver", ver_smart_bus_out, 0);
        chk("start_wins_busy", busy, 1);
        tick();
        chk("bypass_ignored_busy", hor_smart_bus_out, 0);
        feed_drain(tbl[2]);
        bypass_en = 1'b0;
        tick();

        // Reset in the middle of a job, then a fresh job must not see stale sums.
        do_start(3);
        in_valid    = 1'b1;
        left_in_bus = tbl[3].left[0];
        top_in_bus  = tbl[3].top[0];
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("midjob_reset");
        do_start(1);
        feed_drain(tbl[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
